jpeg_rle_enc: RTL and testbench

//  Per-component DC-differential and AC run-length encoder; sits directly downstream of quantization.

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/jpeg_vli.sv | 29 ++
 rtl/jpeg_rle_enc.sv | 103 ++++++++++
 tb/tb_jpeg_rle_enc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and symbol bundle for the JPEG entropy front end.
// Used by quantization, run-length and Huffman stages.
package jpeg_pkg;

    localparam int DW        = 11;
    localparam int SW        = 4;
    localparam int BLK_COEFS = 64;
    localparam int ZRL_RUN   = 16;

    localparam logic [5:0] LAST_IDX = 6'(BLK_COEFS - 1);

    // Huffman run/size byte codes for the two special AC symbols
    localparam logic [7:0] SYM_EOB = 8'h00;
    localparam logic [7:0] SYM_ZRL = 8'hF0;

    typedef struct packed {
        logic          dc;
        logic          eob;
        logic [1:0]    zrl;
        logic [3:0]    run;
        logic [SW-1:0] size;
        logic [DW-1:0] amp;
        logic          done;
    } sym_t;

endpackage

// File: rtl/jpeg_vli.sv
// Magnitude category and VLI amplitude of a signed value.
// Negative values map to the low size bits of (value - 1).
module jpeg_vli
    import jpeg_pkg::*;
(
    input  logic signed [DW:0] val_i,
    output logic [SW-1:0]      size_o,
    output logic [DW-1:0]      amp_o
);

    logic [DW:0]   mag;
    logic [DW-1:0] vm1;
    logic [DW-1:0] mask;

    always_comb begin
        mag = val_i[DW] ? -val_i : val_i;
        size_o = '0;
        for (int i = 0; i <= DW; i++) begin
            if (mag[i]) size_o = SW'(i + 1);
        end
        mask = '0;
        for (int i = 0; i < DW; i++) begin
            mask[i] = (SW'(i) < size_o);
        end
        vm1 = val_i[DW-1:0] - 1'b1;
        amp_o = val_i[DW] ? (vm1 & mask) : val_i[DW-1:0];
    end

endmodule

// File: rtl/jpeg_rle_enc.sv
// DC-differential and AC run-length encoder for one colour component.
// One zigzag coefficient in, at most one registered symbol out per cycle.
module jpeg_rle_enc
    import jpeg_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          sof,
    input  logic          q_data_valid,
    input  logic [DW-1:0] q_data,
    output logic          sym_valid,
    output logic          sym_dc,
    output logic          sym_eob,
    output logic [1:0]    sym_zrl,
    output logic [3:0]    sym_run,
    output logic [SW-1:0] sym_size,
    output logic [DW-1:0] sym_amp,
    output logic          blk_done
);

    logic [5:0]       idx_q, idx_d, cur_idx;
    logic [5:0]       zcnt_q, zcnt_d;
    logic [DW-1:0]    pred_q, pred_d, cur_pred;
    logic             vld_q, vld_d;
    sym_t             sym_q, sym_d;
    logic signed [DW:0] diff, vli_in;
    logic [SW-1:0]    size;
    logic [DW-1:0]    amp;

    jpeg_vli u_vli (
        .val_i  (vli_in),
        .size_o (size),
        .amp_o  (amp)
    );

    // sof clears block state in the same cycle a coefficient may arrive
    always_comb begin
        cur_idx  = sof ? '0 : idx_q;
        cur_pred = sof ? '0 : pred_q;
        diff     = {q_data[DW-1], q_data} - {cur_pred[DW-1], cur_pred};
        vli_in   = (cur_idx == '0) ? diff : {q_data[DW-1], q_data};
        idx_d    = cur_idx;
        zcnt_d   = sof ? '0 : zcnt_q;
        pred_d   = cur_pred;
        vld_d    = 1'b0;
        sym_d    = '0;
        if (q_data_valid) begin
            idx_d = cur_idx + 6'd1;
            priority case (1'b1)
                (cur_idx == '0): begin
                    vld_d      = 1'b1;
                    sym_d.dc   = 1'b1;
                    sym_d.size = size;
                    sym_d.amp  = amp;
                    pred_d     = q_data;
                    zcnt_d     = '0;
                end
                (q_data != '0): begin
                    vld_d      = 1'b1;
                    sym_d.zrl  = zcnt_d[5:4];
                    sym_d.run  = zcnt_d[3:0];
                    sym_d.size = size;
                    sym_d.amp  = amp;
                    sym_d.done = (cur_idx == LAST_IDX);
                    zcnt_d     = '0;
                end
                (cur_idx == LAST_IDX): begin
                    vld_d      = 1'b1;
                    sym_d.eob  = 1'b1;
                    sym_d.done = 1'b1;
                    zcnt_d     = '0;
                end
                default: zcnt_d = zcnt_d + 6'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= '0;
            zcnt_q <= '0;
            pred_q <= '0;
            vld_q  <= 1'b0;
            sym_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            zcnt_q <= zcnt_d;
            pred_q <= pred_d;
            vld_q  <= vld_d;
            sym_q  <= sym_d;
        end
    end

    assign sym_valid = vld_q;
    assign sym_dc    = sym_q.dc;
    assign sym_eob   = sym_q.eob;
    assign sym_zrl   = sym_q.zrl;
    assign sym_run   = sym_q.run;
    assign sym_size  = sym_q.size;
    assign sym_amp   = sym_q.amp;
    assign blk_done  = sym_q.done;

endmodule

// File: tb/tb_jpeg_rle_enc.sv
// Self-checking bench for jpeg_rle_enc: directed table, corner sequences,
// and random blocks against a block-level symbol model.
module tb_jpeg_rle_enc;
    import jpeg_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sof;
    logic          q_data_valid;
    logic [DW-1:0] q_data;
    logic          sym_valid;
    logic          sym_dc;
    logic          sym_eob;
    logic [1:0]    sym_zrl;
    logic [3:0]    sym_run;
    logic [SW-1:0] sym_size;
    logic [DW-1:0] sym_amp;
    logic          blk_done;

    jpeg_rle_enc dut (
        .clk          (clk),
        .rstn         (rstn),
        .sof          (sof),
        .q_data_valid (q_data_valid),
        .q_data       (q_data),
        .sym_valid    (sym_valid),
        .sym_dc       (sym_dc),
        .sym_eob      (sym_eob),
        .sym_zrl      (sym_zrl),
        .sym_run      (sym_run),
        .sym_size     (sym_size),
        .sym_amp      (sym_amp),
        .blk_done     (blk_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dc;
        logic        eob;
        logic [1:0]  zrl;
        logic [3:0]  run;
        logic [3:0]  size;
        logic [10:0] amp;
        logic        done;
    } esym_t;

    typedef struct {
        logic  s;
        int    pre;
        int    data;
        esym_t e;
    } row_t;

    int    n_chk = 0;
    int    n_fail = 0;
    logic  cap = 1'b0;
    esym_t got[$];
    esym_t expq[$];
    row_t  rows[16];

    function automatic esym_t mk(bit dc, bit eob, int zrl, int run,
                                 int size, int amp, bit done);
        esym_t r;
        r.dc   = dc;
        r.eob  = eob;
        r.zrl  = 2'(zrl);
        r.run  = 4'(run);
        r.size = 4'(size);
        r.amp  = 11'(amp);
        r.done = done;
        return r;
    endfunction

    function automatic esym_t act();
        esym_t r;
        r.dc   = sym_dc;
        r.eob  = sym_eob;
        r.zrl  = sym_zrl;
        r.run  = sym_run;
        r.size = sym_size;
        r.amp  = sym_amp;
        r.done = blk_done;
        return r;
    endfunction

    function automatic int cat(int v);
        int m = (v < 0) ? -v : v;
        int s = 0;
        while (m > 0) begin
            s++;
            m = m / 2;
        end
        return s;
    endfunction

    function automatic int vli(int v);
        if (v >= 0) return v;
        return v + (1 << cat(v)) - 1;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input logic s, input logic v, input int d);
        sof = s;
        q_data_valid = v;
        q_data = d[DW-1:0];
        @(posedge clk);
        #1;
        sof = 1'b0;
        q_data_valid = 1'b0;
        if (cap && sym_valid) got.push_back(act());
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #2;
        chk("reset outputs", 32'({sym_valid, act()}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int bad;
        int c[64];
        int pred;
        int z;

        rstn = 1'b0;
        sof = 1'b0;
        q_data_valid = 1'b0;
        q_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'({sym_valid, act()}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        rows[0]  = '{1'b1, 0,  5,     mk(1, 0, 0, 0, 3,  5,     0)};
        rows[1]  = '{1'b0, 62, 0,     mk(0, 1, 0, 0, 0,  0,     1)};
        rows[2]  = '{1'b0, 0,  3,     mk(1, 0, 0, 0, 2,  1,     0)};
        rows[3]  = '{1'b0, 0,  -1,    mk(0, 0, 0, 0, 1,  0,     0)};
        rows[4]  = '{1'b0, 61, 0,     mk(0, 1, 0, 0, 0,  0,     1)};
        rows[5]  = '{1'b0, 0,  3,     mk(1, 0, 0, 0, 0,  0,     0)};
        rows[6]  = '{1'b0, 35, 7,     mk(0, 0, 2, 3, 3,  7,     0)};
        rows[7]  = '{1'b0, 26, 0,     mk(0, 1, 0, 0, 0,  0,     1)};
        rows[8]  = '{1'b0, 0,  -1024, mk(1, 0, 0, 0, 11, 'h3FC, 0)};
        rows[9]  = '{1'b0, 62, 1,     mk(0, 0, 3, 14, 1, 1,     1)};
        rows[10] = '{1'b0, 0,  1023,  mk(1, 0, 0, 0, 11, 'h7FF, 0)};
        rows[11] = '{1'b0, 0,  -1024, mk(0, 0, 0, 0, 11, 'h3FF, 0)};
        rows[12] = '{1'b0, 61, 0,     mk(0, 1, 0, 0, 0,  0,     1)};
        rows[13] = '{1'b0, 0,  100,   mk(1, 0, 0, 0, 10, 100,   0)};
        rows[14] = '{1'b1, 5,  8,     mk(1, 0, 0, 0, 4,  8,     0)};
        rows[15] = '{1'b0, 62, 0,     mk(0, 1, 0, 0, 0,  0,     1)};

        for (int r = 0; r < 16; r++) begin
            bad = 0;
            for (int k = 0; k < rows[r].pre; k++) begin
                step(1'b0, 1'b1, 0);
                if (sym_valid) bad++;
            end
            if (rows[r].pre > 0)
                chk($sformatf("row%0d zero-run quiet", r), 32'(bad), 32'd0);
            step(rows[r].s, 1'b1, rows[r].data);
            chk($sformatf("row%0d valid", r), 32'(sym_valid), 32'd1);
            chk($sformatf("row%0d symbol", r), 32'(act()), 32'(rows[r].e));
        end

        // gapped block, sof at idx 20 without a coefficient, then reset
        step(1'b0, 1'b1, 50);
        chk("gap dc", 32'(act()), 32'(mk(1, 0, 0, 0, 6, 42, 0)));
        bad = 0;
        for (int i = 1; i < 20; i++) begin
            if (i % 2 == 1) begin
                step(1'b0, 1'b0, 0);
                if (sym_valid) bad++;
            end
            step(1'b0, 1'b1, 0);
            if (sym_valid) bad++;
        end
        chk("gap quiet", 32'(bad), 32'd0);
        step(1'b1, 1'b0, 0);
        chk("sof idle valid", 32'(sym_valid), 32'd0);
        step(1'b0, 1'b1, 6);
        chk("post-sof dc", 32'({sym_valid, act()}),
            32'({1'b1, mk(1, 0, 0, 0, 3, 6, 0)}));
        step(1'b0, 1'b1, -3);
        chk("post-sof ac", 32'({sym_valid, act()}),
            32'({1'b1, mk(0, 0, 0, 0, 2, 0, 0)}));
        step(1'b0, 1'b0, 0);
        chk("idle cycle", 32'({sym_valid, act()}), 32'd0);
        pulse_reset();
        step(1'b0, 1'b1, 9);
        chk("post-reset dc", 32'({sym_valid, act()}),
            32'({1'b1, mk(1, 0, 0, 0, 4, 9, 0)}));

        // random blocks against the model
        pulse_reset();
        cap = 1'b1;
        pred = 0;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 64; i++) begin
                if (i == 0 || $urandom_range(0, 4) == 0)
                    c[i] = int'($urandom_range(0, 2047)) - 1024;
                else
                    c[i] = 0;
            end
            if (b == 0) c[0] = -1024;
            if (b == 1) c[0] = 1023;
            expq.push_back(mk(1, 0, 0, 0, cat(c[0] - pred),
                              vli(c[0] - pred), 0));
            pred = c[0];
            z = 0;
            for (int i = 1; i < 64; i++) begin
                if (c[i] != 0) begin
                    expq.push_back(mk(0, 0, z / ZRL_RUN, z % ZRL_RUN,
                                      cat(c[i]), vli(c[i]), i == 63));
                    z = 0;
                end else if (i == 63) begin
                    expq.push_back(mk(0, 1, 0, 0, 0, 0, 1));
                end else begin
                    z++;
                end
            end
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 0);
                step(1'b0, 1'b1, c[i]);
            end
        end
        step(1'b0, 1'b0, 0);
        cap = 1'b0;
        chk("random symbol count", 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("random sym %0d", i), 32'(got[i]), 32'(expq[i]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
